// File: rtl/goal_freq_ctrl.sv
// Target-frequency setpoint with clamped inc/dec commands and a slew-limited ramp of the live word.
// Define FREQ_ACK_EN to build the one-byte UART acknowledge path (start/busy handshake).
module goal_freq_ctrl #(
  parameter int unsigned FREQ_W    = 16,
  parameter int unsigned FREQ_MIN  = 100,
  parameter int unsigned FREQ_MAX  = 10000,
  parameter int unsigned FREQ_INIT = 1000,
  parameter int unsigned STEP      = 100,
  parameter int unsigned RAMP_DIV  = 50000,
  parameter int unsigned RAMP_STEP = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Goal_inc,
  input  logic              Goal_dec,
  output logic [FREQ_W-1:0] goal_freq,
  output logic [FREQ_W-1:0] cur_freq,
  output logic              ramp_busy,
  output logic              at_limit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  localparam int unsigned PRESC_W = $clog2(RAMP_DIV);

  localparam logic [FREQ_W:0]    MAX_X      = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W:0]    STEP_X     = (FREQ_W+1)'(STEP);
  localparam logic [FREQ_W:0]    MINSTEP_X  = (FREQ_W+1)'(FREQ_MIN + STEP);
  localparam logic [FREQ_W-1:0]  MIN_W      = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0]  MAX_W      = FREQ_W'(FREQ_MAX);
  localparam logic [FREQ_W-1:0]  INIT_W     = FREQ_W'(FREQ_INIT);
  localparam logic [FREQ_W-1:0]  STEP_W     = FREQ_W'(STEP);
  localparam logic [FREQ_W-1:0]  RSTEP_W    = FREQ_W'(RAMP_STEP);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
  localparam logic               INIT_LIM   = (FREQ_INIT == FREQ_MIN) || (FREQ_INIT == FREQ_MAX);

  logic [FREQ_W-1:0]  goalFreq_q, goal_d;
  logic [FREQ_W-1:0]  curFreq_q, cur_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               rampBusy_q;
  logic               atLimit_q;

  logic               incOnly;
  logic               decOnly;
  logic [FREQ_W:0]    incSum;
  logic [FREQ_W-1:0]  incGoal;
  logic [FREQ_W-1:0]  decGoal;
  logic               goalUp;
  logic [FREQ_W-1:0]  rampDiff;
  logic [FREQ_W-1:0]  rampDelta;

  assign incOnly = Goal_inc & ~Goal_dec;
  assign decOnly = Goal_dec & ~Goal_inc;

  // The increment is formed one bit wider so a setpoint near the top of the word cannot wrap.
  assign incSum  = {1'b0, goalFreq_q} + STEP_X;
  assign incGoal = (incSum > MAX_X) ? MAX_W : incSum[FREQ_W-1:0];
  assign decGoal = ({1'b0, goalFreq_q} < MINSTEP_X) ? MIN_W : (goalFreq_q - STEP_W);

  always_comb begin
    goal_d = goalFreq_q;
    if (incOnly) begin
      goal_d = incGoal;
    end else if (decOnly) begin
      goal_d = decGoal;
    end
  end

  assign goalUp    = goalFreq_q > curFreq_q;
  assign rampDiff  = goalUp ? (goalFreq_q - curFreq_q) : (curFreq_q - goalFreq_q);
  assign rampDelta = (rampDiff < RSTEP_W) ? rampDiff : RSTEP_W;

  // Ramp steps use the goal as it stands at the terminal count, so a mid-ramp change redirects without restarting the prescaler.
  always_comb begin
    presc_d = '0;
    cur_d   = curFreq_q;
    if (curFreq_q != goalFreq_q) begin
      if (presc_q == PRESC_LAST) begin
        cur_d = goalUp ? (curFreq_q + rampDelta) : (curFreq_q - rampDelta);
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      goalFreq_q <= INIT_W;
      curFreq_q  <= INIT_W;
      presc_q    <= '0;
      rampBusy_q <= 1'b0;
      atLimit_q  <= INIT_LIM;
    end else begin
      goalFreq_q <= goal_d;
      curFreq_q  <= cur_d;
      presc_q    <= presc_d;
      rampBusy_q <= (cur_d != goal_d);
      atLimit_q  <= (goal_d == MIN_W) || (goal_d == MAX_W);
    end
  end

  assign goal_freq = goalFreq_q;
  assign cur_freq  = curFreq_q;
  assign ramp_busy = rampBusy_q;
  assign at_limit  = atLimit_q;

`ifdef FREQ_ACK_EN
  localparam logic [1:0] ACK_IDLE    = 2'd0;
  localparam logic [1:0] ACK_SEND    = 2'd1;
  localparam logic [1:0] ACK_WAIT_HI = 2'd2;
  localparam logic [1:0] ACK_WAIT_LO = 2'd3;
  localparam logic [3:0] HS_LAST     = 4'd15;

  logic [1:0] ackState_q, ackState_d;
  logic       pending_q, pending_d;
  logic [7:0] pendByte_q, pendByte_d;
  logic [3:0] hsTimer_q, hsTimer_d;
  logic [7:0] cmdByte;

  always_comb begin
    cmdByte = 8'h3F;
    if (incOnly) begin
      cmdByte = (goal_d != goalFreq_q) ? 8'h2B : 8'h4C;
    end else if (decOnly) begin
      cmdByte = (goal_d != goalFreq_q) ? 8'h2D : 8'h4C;
    end
  end

  // A new command always lands in the single pending slot last, so it beats the clear done in SEND.
  always_comb begin
    ackState_d = ackState_q;
    hsTimer_d  = hsTimer_q;
    pending_d  = pending_q;
    pendByte_d = pendByte_q;
    case (ackState_q)
      ACK_IDLE: begin
        if (pending_q && !tx_busy) ackState_d = ACK_SEND;
      end
      ACK_SEND: begin
        ackState_d = ACK_WAIT_HI;
        hsTimer_d  = '0;
        pending_d  = 1'b0;
      end
      ACK_WAIT_HI: begin
        if (tx_busy) begin
          ackState_d = ACK_WAIT_LO;
        end else if (hsTimer_q == HS_LAST) begin
          ackState_d = ACK_IDLE;
        end else begin
          hsTimer_d = hsTimer_q + 4'd1;
        end
      end
      ACK_WAIT_LO: begin
        if (!tx_busy) ackState_d = ACK_IDLE;
      end
      default: ackState_d = ACK_IDLE;
    endcase
    if (Goal_inc || Goal_dec) begin
      pending_d  = 1'b1;
      pendByte_d = cmdByte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ackState_q <= ACK_IDLE;
      hsTimer_q  <= '0;
      pending_q  <= 1'b0;
      pendByte_q <= 8'h00;
    end else begin
      ackState_q <= ackState_d;
      hsTimer_q  <= hsTimer_d;
      pending_q  <= pending_d;
      pendByte_q <= pendByte_d;
    end
  end

  assign tx_start = (ackState_q == ACK_SEND);
  assign tx_data  = tx_start ? pendByte_q : 8'h00;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_start       = 1'b0;
  assign tx_data        = 8'h00;
`endif

endmodule
